alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width (legal values 8..64, power of two).
REQ-002 The block SHALL have localparam SHW = $clog2(WIDTH), giving the shift-amount width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 alu_op  input  2  main-control ALU opcode.
REQ-008 instruction_5_0  input  6  R-type funct field.
REQ-009 operand_a, operand_b  input  WIDTH each  source operands; operand_b[SHW-1:0] is the shift amount for shifts.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  registered result (LO word for MULT).
REQ-013 hi  output  WIDTH  registered upper product word (MULT only, else 0).
REQ-014 zero  output  1  registered, result == 0.
REQ-015 alu_ctl  output  4  registered decoded control of the completed op.
REQ-016 illegal  output  1  registered, the completed op was an undefined encoding.

Function
REQ-017 Decode SHALL be: alu_op 00 -> ADD 0010; 01 -> SUB 0110; 11 -> illegal; 10 -> by funct: 100000 ADD 0010, 100010 SUB 0110, 100100 AND 0000, 100101 OR 0001, 101010 SLT 0111, 100111 NOR 1100, 000000 SLL 0011, 000010 SRL 0100, 011000 MULT 1110, any other funct -> illegal.
REQ-018 An illegal op SHALL complete as a single-cycle op with alu_ctl 1111, result 0, hi 0, illegal 1.
REQ-019 ADD/SUB SHALL wrap modulo 2^WIDTH with no overflow flag; SLT SHALL compare signed and return 1 or 0, zero-extended.
REQ-020 SLL/SRL SHALL be logical shifts of operand_a by operand_b[SHW-1:0].
REQ-021 MULT SHALL be an unsigned iterative shift-add multiply producing a 2*WIDTH product, {hi,result}, using one iteration per cycle.
REQ-022 The FSM SHALL have states IDLE, MUL and DONE.
REQ-023 IDLE: on accept, a single-cycle op SHALL go to DONE; MULT SHALL go to MUL with its iteration counter set to 0.
REQ-024 MUL: the counter SHALL increment each cycle, and after WIDTH iterations the FSM SHALL go to DONE.
REQ-025 DONE: if out_ready and no new accept, the FSM SHALL return to IDLE; if out_ready with a simultaneous accept, it SHALL branch as from IDLE.
REQ-026 Accept SHALL occur when in_valid && in_ready, with in_ready = (state==IDLE) || (state==DONE && out_ready).
REQ-027 Inputs SHALL be sampled only on accept, and operand changes after accept SHALL have no effect.
REQ-028 Latency: a single-cycle op accepted at edge N SHALL give out_valid=1 after edge N; a MULT accepted at edge N SHALL give out_valid=1 after edge N+WIDTH.
REQ-029 out_valid SHALL equal (state==DONE), and result, hi, zero, alu_ctl and illegal SHALL hold stable while out_valid && !out_ready.
REQ-030 Back-to-back single-cycle ops with out_ready held 1 SHALL sustain one result per cycle.
REQ-031 result/hi SHALL NOT change during MUL until DONE is entered; internal accumulators are separate registers.

Reset
REQ-032 On rst: state IDLE, out_valid 0, result 0, hi 0, zero 0, alu_ctl 0000, illegal 0, counter 0.
REQ-033 rst asserted mid-MULT SHALL abort the op with no result ever presented; the first accept after deassertion SHALL behave normally.

Structure
REQ-034 Package alu_pkg SHALL hold the alu_op codes, funct codes, 4-bit ALU control codes (incl. 1111 illegal) and the FSM state enum.
REQ-035 Decode SHALL be a combinational sub-module alu_decode (alu_op, instruction_5_0 -> alu_ctl, is_mult, illegal), instantiated once.

Verification
REQ-036 The bench SHALL cover WIDTH=32 with out_ready=1: alu_op 10 funct 100010, a=5, b=7 -> result FFFFFFFE, zero 0, alu_ctl 0110, one cycle after accept.
REQ-037 The bench SHALL cover SLT: alu_op 10 funct 101010, a=FFFFFFFF, b=1 -> result 1; then a=b=3 with funct 100010 -> result 0, zero 1.
REQ-038 The bench SHALL cover MULT: a=FFFFFFFF, b=2 -> hi 00000001, result FFFFFFFE, out_valid exactly 32 cycles after accept, in_ready 0 during MUL.
REQ-039 The bench SHALL cover stall: out_ready=0 for 5 cycles after an AND (a=F0F0, b=FF00) -> result 0000F000 held, in_ready 0, then released on out_ready.
REQ-040 The bench SHALL cover illegal: alu_op 11, then alu_op 10 funct 111111 -> illegal 1, alu_ctl 1111, result 0 in both cases.
REQ-041 The bench SHALL cover reset abort: rst pulsed at MUL cycle 10 -> out_valid stays 0, outputs 0; the following ADD a=2, b=3 -> result 5.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the ALU execute unit.
// Holds main-control alu_op codes, R-type funct codes, 4-bit ALU control
// codes (including the illegal marker) and the execute FSM state type.
package alu_pkg;

  // Main-control alu_op encodings
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ILL   = 2'b11;

  // R-type funct encodings
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_MULT = 6'b011000;

  // Decoded ALU control codes
  typedef enum logic [3:0] {
    CTL_AND     = 4'b0000,
    CTL_OR      = 4'b0001,
    CTL_ADD     = 4'b0010,
    CTL_SLL     = 4'b0011,
    CTL_SRL     = 4'b0100,
    CTL_SUB     = 4'b0110,
    CTL_SLT     = 4'b0111,
    CTL_NOR     = 4'b1100,
    CTL_MULT    = 4'b1110,
    CTL_ILLEGAL = 4'b1111
  } alu_ctl_t;

  // Execute FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_exec_unit_decode.sv
// alu_decode: combinational ALU control decoder.
// Ports: alu_op/instruction_5_0 in; alu_ctl (4-bit control), is_mult and
// illegal out. Undefined encodings report CTL_ILLEGAL with illegal=1.
module alu_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] instruction_5_0,
  output logic [3:0] alu_ctl,
  output logic       is_mult,
  output logic       illegal
);

  always_comb begin
    alu_ctl = CTL_ILLEGAL;
    is_mult = 1'b0;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_ctl = CTL_ADD;
      ALUOP_SUB: alu_ctl = CTL_SUB;
      ALUOP_RTYPE: begin
        case (instruction_5_0)
          FUNCT_ADD:  alu_ctl = CTL_ADD;
          FUNCT_SUB:  alu_ctl = CTL_SUB;
          FUNCT_AND:  alu_ctl = CTL_AND;
          FUNCT_OR:   alu_ctl = CTL_OR;
          FUNCT_SLT:  alu_ctl = CTL_SLT;
          FUNCT_NOR:  alu_ctl = CTL_NOR;
          FUNCT_SLL:  alu_ctl = CTL_SLL;
          FUNCT_SRL:  alu_ctl = CTL_SRL;
          FUNCT_MULT: begin
            alu_ctl = CTL_MULT;
            is_mult = 1'b1;
          end
          default: begin
            alu_ctl = CTL_ILLEGAL;
            illegal = 1'b1;
          end
        endcase
      end
      default: begin
        alu_ctl = CTL_ILLEGAL;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: ALU execute stage with a valid/ready handshake on both sides.
// Ports: clk/rst; in_valid/in_ready with alu_op, instruction_5_0, operand_a/b;
// out_valid/out_ready with registered result, hi, zero, alu_ctl, illegal.
// Single-cycle ops complete the edge they are accepted; MULT takes WIDTH more
// cycles of shift-add. Outputs hold while out_valid && !out_ready.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       instruction_5_0,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic [3:0]       alu_ctl,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state;
  logic [SHW-1:0]   cnt;
  // Multiplier working registers, kept apart from result/hi so the visible
  // outputs only change when the product is complete.
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic [3:0]       dec_ctl;
  logic             dec_mult;
  logic             dec_ill;
  logic             accept;
  logic [WIDTH-1:0] sc_res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;

  alu_decode u_decode (
    .alu_op          (alu_op),
    .instruction_5_0 (instruction_5_0),
    .alu_ctl         (dec_ctl),
    .is_mult         (dec_mult),
    .illegal         (dec_ill)
  );

  // A finished result being consumed frees the unit in the same cycle.
  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);

  // Single-cycle datapath; illegal and MULT codes fall through to zero.
  always_comb begin
    sc_res = '0;
    case (dec_ctl)
      CTL_ADD: sc_res = operand_a + operand_b;
      CTL_SUB: sc_res = operand_a - operand_b;
      CTL_AND: sc_res = operand_a & operand_b;
      CTL_OR:  sc_res = operand_a | operand_b;
      CTL_NOR: sc_res = ~(operand_a | operand_b);
      CTL_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      CTL_SLL: sc_res = operand_a << operand_b[SHW-1:0];
      CTL_SRL: sc_res = operand_a >> operand_b[SHW-1:0];
      default: sc_res = '0;
    endcase
  end

  // One shift-add step: conditionally add the multiplicand into the upper
  // half, then shift the {carry, hi, lo} chain right by one. The multiplier
  // starts in acc_lo and is consumed from its LSB as product bits shift in.
  always_comb begin
    mul_sum = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, mcand}) : {1'b0, acc_hi};
    nxt_hi  = mul_sum[WIDTH:1];
    nxt_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      result  <= '0;
      hi      <= '0;
      zero    <= 1'b0;
      alu_ctl <= 4'b0000;
      illegal <= 1'b0;
    end else if (accept) begin
      // Accept only happens from IDLE or from DONE while being drained,
      // so both cases branch identically here.
      if (dec_mult) begin
        state  <= ST_MUL;
        cnt    <= '0;
        mcand  <= operand_a;
        acc_hi <= '0;
        acc_lo <= operand_b;
      end else begin
        state   <= ST_DONE;
        result  <= sc_res;
        hi      <= '0;
        zero    <= (sc_res == '0);
        alu_ctl <= dec_ctl;
        illegal <= dec_ill;
      end
    end else begin
      case (state)
        ST_MUL: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          if (cnt == SHW'(WIDTH-1)) begin
            state   <= ST_DONE;
            cnt     <= '0;
            result  <= nxt_lo;
            hi      <= nxt_hi;
            zero    <= (nxt_lo == '0);
            alu_ctl <= CTL_MULT;
            illegal <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit at WIDTH=32: the driver pushes the
// expected response of every accepted request, a negedge monitor compares
// each delivered result and its arrival cycle.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    alu_op = 2'b00;
  logic [5:0]    instruction_5_0 = 6'd0;
  logic [W-1:0]  operand_a = '0;
  logic [W-1:0]  operand_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic [W-1:0]  hi;
  logic          zero;
  logic [3:0]    alu_ctl;
  logic          illegal;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .alu_op          (alu_op),
    .instruction_5_0 (instruction_5_0),
    .operand_a       (operand_a),
    .operand_b       (operand_b),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .result          (result),
    .hi              (hi),
    .zero            (zero),
    .alu_ctl         (alu_ctl),
    .illegal         (illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         zero;
    logic [3:0]   ctl;
    logic         ill;
    int           lat;
    int           vcyc;
  } exp_t;

  exp_t sbq[$];
  int   n_pass = 0;
  int   n_total = 0;
  bit   fresh = 1'b1;
  bit   rnd_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // Reference model: straight from the operation definitions.
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] f,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] p;
    int          sh;
    e.res = '0; e.hi = '0; e.ctl = 4'hF; e.ill = 1'b1; e.lat = 0; e.vcyc = 0;
    sh = int'(b % W);
    if (op == 2'b00) begin
      e.ctl = 4'h2; e.ill = 0; e.res = a + b;
    end else if (op == 2'b01) begin
      e.ctl = 4'h6; e.ill = 0; e.res = a - b;
    end else if (op == 2'b10) begin
      e.ill = 0;
      case (f)
        6'b100000: begin e.ctl = 4'h2; e.res = a + b; end
        6'b100010: begin e.ctl = 4'h6; e.res = a - b; end
        6'b100100: begin e.ctl = 4'h0; e.res = a & b; end
        6'b100101: begin e.ctl = 4'h1; e.res = a | b; end
        6'b101010: begin e.ctl = 4'h7; e.res = ($signed(a) < $signed(b)) ? 1 : 0; end
        6'b100111: begin e.ctl = 4'hC; e.res = ~(a | b); end
        6'b000000: begin e.ctl = 4'h3; e.res = a << sh; end
        6'b000010: begin e.ctl = 4'h4; e.res = a >> sh; end
        6'b011000: begin
          e.ctl = 4'hE; p = 64'(a) * 64'(b);
          e.res = p[31:0]; e.hi = p[63:32]; e.lat = W;
        end
        default: begin e.ctl = 4'hF; e.ill = 1; end
      endcase
    end
    e.zero = (e.res == 0);
    return e;
  endfunction

  // Monitor: latency on first sight of each result, data on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid), 64'(0));
      end else begin
        if (fresh) begin
          chk("latency_cycle", 64'(cyc), 64'(sbq[0].vcyc));
          fresh = 1'b0;
        end
        if (out_ready) begin
          chk("result", 64'(result), 64'(sbq[0].res));
          chk("hi", 64'(hi), 64'(sbq[0].hi));
          chk("zero", 64'(zero), 64'(sbq[0].zero));
          chk("alu_ctl", 64'(alu_ctl), 64'(sbq[0].ctl));
          chk("illegal", 64'(illegal), 64'(sbq[0].ill));
          void'(sbq.pop_front());
          fresh = 1'b1;
        end
      end
    end
  end

  // Called and returns at a negedge. Operands are scrambled after accept.
  task automatic issue(input logic [1:0] op, input logic [5:0] f,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   n;
    bit   go;
    alu_op = op; instruction_5_0 = f; operand_a = a; operand_b = b; in_valid = 1'b1;
    n = 0; go = 1'b0;
    while (!go && n < 300) begin
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
      #4;
      go = in_ready;
      @(posedge clk);
      #1;
      if (go) begin
        e = model(op, f, a, b);
        e.vcyc = cyc + e.lat;
        sbq.push_back(e);
      end
      @(negedge clk);
      n++;
    end
    if (!go) chk("accept_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
    operand_a = $urandom; operand_b = $urandom;
    alu_op = 2'($urandom); instruction_5_0 = 6'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 500) begin
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) chk("drain_timeout", 64'(sbq.size()), 64'(0));
    @(negedge clk);
  endtask

  initial begin
    int         bad;
    logic [5:0] ftab [9];
    logic [5:0] f;
    logic [1:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    ftab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
             6'b100111, 6'b000000, 6'b000010, 6'b011000};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_zero", 64'(zero), 64'(0));
    chk("rst_alu_ctl", 64'(alu_ctl), 64'(0));
    chk("rst_illegal", 64'(illegal), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'(1));

    // SUB wrap, SLT signed, SUB to zero
    issue(2'b10, 6'b100010, 32'd5, 32'd7);
    drain();
    issue(2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1);
    drain();
    issue(2'b10, 6'b100010, 32'd3, 32'd3);
    drain();

    // MULT: unit busy for all WIDTH cycles
    issue(2'b10, 6'b011000, 32'hFFFFFFFF, 32'd2);
    bad = 0;
    for (int i = 0; i < W; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("mul_busy_cycles", 64'(bad), 64'(0));
    drain();

    // Stall: AND result held for 5 cycles with out_ready low
    out_ready = 1'b0;
    issue(2'b10, 6'b100100, 32'h0000F0F0, 32'h0000FF00);
    for (int i = 0; i < 5; i++) begin
      chk("stall_result", 64'(result), 64'h0000F000);
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      chk("stall_out_valid", 64'(out_valid), 64'(1));
      @(negedge clk);
    end
    out_ready = 1'b1;
    drain();

    // Illegal encodings
    issue(2'b11, 6'b100000, 32'd9, 32'd9);
    issue(2'b10, 6'b111111, 32'd9, 32'd9);
    drain();

    // Back-to-back single-cycle ops
    for (int i = 0; i < 6; i++) issue(2'b00, 6'd0, 32'(i * 3), 32'(i));
    drain();

    // Reset aborts an in-flight MULT
    issue(2'b10, 6'b011000, 32'h12345678, 32'h9ABCDEF0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    fresh = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_result", 64'(result), 64'(0));
    chk("abort_hi", 64'(hi), 64'(0));
    chk("abort_alu_ctl", 64'(alu_ctl), 64'(0));
    bad = 0;
    for (int i = 0; i < W + 8; i++) begin
      if (out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("abort_no_valid", 64'(bad), 64'(0));
    issue(2'b00, 6'd0, 32'd2, 32'd3);
    chk("post_abort_add", 64'(result), 64'd5);
    drain();

    // Randomized traffic with random backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0: op = 2'b00;
        1: op = 2'b01;
        2: op = 2'b11;
        default: op = 2'b10;
      endcase
      if ($urandom_range(0, 9) == 9) f = 6'($urandom);
      else f = ftab[$urandom_range(0, 8)];
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFFF;
      if ($urandom_range(0, 3) == 0) b = a;
      issue(op, f, a, b);
    end
    drain();
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
